// File: rtl/alu_pkg.sv
// alu_pkg
// Shared definitions for the accumulator ALU and its round-robin scheduler:
// ALU operation encodings, the no-op the scheduler drives when nothing
// issues, the scheduler FSM states and a small wrap-around helper.
// Ports: none (package).
package alu_pkg;

   typedef enum logic [1:0] {
      ALU_ADD = 2'd0,
      ALU_SUB = 2'd1,
      ALU_OR  = 2'd2,
      ALU_XOR = 2'd3
   } alu_op_e;

   // The ALU updates its accumulator every cycle, so "nothing to do" has to
   // be expressed as an operation that leaves the accumulator unchanged.
   localparam alu_op_e    ALU_NOP_OP      = ALU_ADD;
   localparam logic [3:0] ALU_NOP_OPERAND = 4'd0;

   typedef enum logic {
      SCHED_IDLE   = 1'b0,
      SCHED_LOCKED = 1'b1
   } sched_state_e;

   // Next requester index after idx, wrapping at n.
   function automatic int wrapInc(input int idx, input int n);
      return (idx + 1) % n;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Combinational round-robin arbiter: picks the first asserted request at or
// above rrPtr_i, wrapping around to index 0.
// Ports:
//   req_i       N   request vector
//   rrPtr_i     IW  highest-priority index this cycle
//   grant_o     N   one-hot grant (zero when nothing requests)
//   grantIdx_o  IW  index of the granted request
//   anyGrant_o  1   some request was granted
module rr_arbiter #(
   parameter  int N  = 4,
   localparam int IW = $clog2(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] rrPtr_i,
   output logic [N-1:0]  grant_o,
   output logic [IW-1:0] grantIdx_o,
   output logic          anyGrant_o
);

   // Walk the candidates from lowest priority to highest so that the last
   // hit written is the one closest to the pointer.
   always_comb begin
      int cand;
      grant_o    = '0;
      grantIdx_o = '0;
      anyGrant_o = 1'b0;
      cand       = 0;
      for (int off = N - 1; off >= 0; off--) begin
         cand = (int'(rrPtr_i) + off) % N;
         if (req_i[cand]) begin
            grant_o       = '0;
            grant_o[cand] = 1'b1;
            grantIdx_o    = IW'(cand);
            anyGrant_o    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_rr_sched.sv
// alu_rr_sched
// Shares one 4-bit accumulator ALU among NUM_REQ requesters. Idle requests
// are arbitrated round-robin; a requester can keep the ALU across several
// operations by holding req_last low, and an idle timeout reclaims locks
// that are left unused. Each accepted op gets a one-cycle response carrying
// the accumulator value after that op.
// Ports:
//   clock, reset_L        rising-edge clock, async active-low reset
//   req_valid/req_ready   per-requester handshake (ready is one-hot or zero)
//   req_op/req_operand    per-requester operation (2b each) and operand (4b each)
//   req_last              1 = release the ALU after this op
//   alu_operation/operand drive the ALU inputs (ADD 0 when nothing issues)
//   alu_result            ALU accumulator value
//   rsp_valid/rsp_id      registered response strobe and requester ID
//   rsp_result            accumulator value in the response cycle
module alu_rr_sched import alu_pkg::*; #(
   parameter  int NUM_REQ      = 4,
   parameter  int LOCK_TIMEOUT = 8,
   localparam int IDW          = $clog2(NUM_REQ)
) (
   input  logic                   clock,
   input  logic                   reset_L,
   input  logic [NUM_REQ-1:0]     req_valid,
   output logic [NUM_REQ-1:0]     req_ready,
   input  logic [2*NUM_REQ-1:0]   req_op,
   input  logic [4*NUM_REQ-1:0]   req_operand,
   input  logic [NUM_REQ-1:0]     req_last,
   output logic [1:0]             alu_operation,
   output logic [3:0]             alu_operand,
   input  logic [3:0]             alu_result,
   output logic                   rsp_valid,
   output logic [IDW-1:0]         rsp_id,
   output logic [3:0]             rsp_result
);

   // The counter only has to reach LOCK_TIMEOUT-1: the cycle that would
   // bring it to LOCK_TIMEOUT is the one that releases the lock.
   localparam int CNT_W     = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
   localparam int CNT_LIMIT = (LOCK_TIMEOUT > 0) ? LOCK_TIMEOUT - 1 : 0;

   sched_state_e       state_q, state_d;
   logic [IDW-1:0]     owner_q, owner_d;
   logic [IDW-1:0]     rrPtr_q, rrPtr_d;
   logic [CNT_W-1:0]   idleCnt_q, idleCnt_d;
   logic               rspValid_q, rspValid_d;
   logic [IDW-1:0]     rspId_q, rspId_d;

   logic [NUM_REQ-1:0] grant;
   logic [IDW-1:0]     grantIdx;
   logic               anyGrant;
   logic               xferAny;
   logic [IDW-1:0]     xferIdx;

   rr_arbiter #(.N(NUM_REQ)) uArbiter (
      .req_i      (req_valid),
      .rrPtr_i    (rrPtr_q),
      .grant_o    (grant),
      .grantIdx_o (grantIdx),
      .anyGrant_o (anyGrant)
   );

   // Ready generation and ALU mux. While locked only the owner may be ready,
   // and only when it is actually requesting; everyone else stalls.
   always_comb begin
      req_ready     = '0;
      alu_operation = ALU_NOP_OP;
      alu_operand   = ALU_NOP_OPERAND;
      if (state_q == SCHED_IDLE) begin
         if (anyGrant) req_ready = grant;
         xferIdx = grantIdx;
      end else begin
         req_ready[owner_q] = req_valid[owner_q];
         xferIdx = owner_q;
      end
      xferAny = |(req_valid & req_ready);
      if (xferAny) begin
         alu_operation = req_op[int'(xferIdx)*2 +: 2];
         alu_operand   = req_operand[int'(xferIdx)*4 +: 4];
      end
   end

   // Next-state logic. A transfer always takes precedence over the idle
   // timeout, so an owner that shows up on the expiring cycle keeps going.
   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      rrPtr_d    = rrPtr_q;
      idleCnt_d  = idleCnt_q;
      rspValid_d = xferAny;
      rspId_d    = rspId_q;
      if (xferAny) begin
         idleCnt_d = '0;
         rspId_d   = xferIdx;
         if (req_last[xferIdx]) begin
            state_d = SCHED_IDLE;
            rrPtr_d = IDW'(wrapInc(int'(xferIdx), NUM_REQ));
         end else begin
            state_d = SCHED_LOCKED;
            owner_d = xferIdx;
         end
      end else if (state_q == SCHED_LOCKED && LOCK_TIMEOUT != 0) begin
         if (idleCnt_q == CNT_W'(CNT_LIMIT)) begin
            state_d   = SCHED_IDLE;
            rrPtr_d   = IDW'(wrapInc(int'(owner_q), NUM_REQ));
            idleCnt_d = '0;
         end else begin
            idleCnt_d = idleCnt_q + 1'b1;
         end
      end
   end

   // State registers; reset drops any response that was about to appear.
   always_ff @(posedge clock or negedge reset_L) begin
      if (!reset_L) begin
         state_q    <= SCHED_IDLE;
         owner_q    <= '0;
         rrPtr_q    <= '0;
         idleCnt_q  <= '0;
         rspValid_q <= 1'b0;
         rspId_q    <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         rrPtr_q    <= rrPtr_d;
         idleCnt_q  <= idleCnt_d;
         rspValid_q <= rspValid_d;
         rspId_q    <= rspId_d;
      end
   end

   // The ALU registers the result on the same edge as the response strobe,
   // so its live output is exactly the post-operation value.
   assign rsp_valid  = rspValid_q;
   assign rsp_id     = rspId_q;
   assign rsp_result = alu_result;

endmodule

// File: tb/tb_alu_rr_sched.sv
// tb_alu_rr_sched
// Directed bench for alu_rr_sched with a behavioural accumulator ALU.
// Stimulus pushes hand-computed responses into a scoreboard queue; a
// separate monitor pops and compares whenever rsp_valid is seen.
// Ports: none (top-level bench).
module tb_alu_rr_sched;

   typedef struct {
      int id;
      int result;
   } exp_t;

   logic        clock;
   logic        reset_L;
   logic [3:0]  req_valid;
   logic [3:0]  req_ready;
   logic [7:0]  req_op;
   logic [15:0] req_operand;
   logic [3:0]  req_last;
   logic [1:0]  alu_operation;
   logic [3:0]  alu_operand;
   logic [3:0]  alu_result;
   logic        rsp_valid;
   logic [1:0]  rsp_id;
   logic [3:0]  rsp_result;
   logic [3:0]  acc;

   exp_t sbQ[$];
   int   checks = 0;
   int   errors = 0;

   alu_rr_sched #(.NUM_REQ(4), .LOCK_TIMEOUT(4)) dut (
      .clock         (clock),
      .reset_L       (reset_L),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_op        (req_op),
      .req_operand   (req_operand),
      .req_last      (req_last),
      .alu_operation (alu_operation),
      .alu_operand   (alu_operand),
      .alu_result    (alu_result),
      .rsp_valid     (rsp_valid),
      .rsp_id        (rsp_id),
      .rsp_result    (rsp_result)
   );

   // Free-running clock, 10 time units per cycle.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Accumulator ALU model: applies whatever is on its inputs every cycle.
   always @(posedge clock or negedge reset_L) begin
      if (!reset_L) acc <= 4'd0;
      else begin
         case (alu_operation)
            2'd0:    acc <= acc + alu_operand;
            2'd1:    acc <= acc - alu_operand;
            2'd2:    acc <= acc | alu_operand;
            default: acc <= acc ^ alu_operand;
         endcase
      end
   end
   assign alu_result = acc;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
      end
   endtask

   // Response monitor: every strobe must match the oldest pending expectation.
   always @(negedge clock) begin
      if (reset_L && rsp_valid) begin
         if (sbQ.size() == 0) begin
            checkOutput("rsp_unexpected", 1, 0);
         end else begin
            exp_t e;
            e = sbQ.pop_front();
            checkOutput("rsp_id", int'(rsp_id), e.id);
            checkOutput("rsp_result", int'(rsp_result), e.result);
         end
      end
   end

   task automatic setReq(input int i, input bit v, input int op, input int operand, input bit last);
      req_valid[i]          = v;
      req_op[i*2 +: 2]      = 2'(op);
      req_operand[i*4 +: 4] = 4'(operand);
      req_last[i]           = last;
   endtask

   task automatic clearAll();
      req_valid   = '0;
      req_op      = '0;
      req_operand = '0;
      req_last    = '0;
   endtask

   // One cycle with the inputs already set: check the combinational issue
   // outputs mid-cycle, record the expected response, then step past the edge.
   task automatic applyStimulus(input string name, input int expReady, input int expOp,
                                input int expOperand, input bit push, input int expId,
                                input int expRes);
      exp_t e;
      @(negedge clock);
      checkOutput({name, "_ready"}, int'(req_ready), expReady);
      checkOutput({name, "_op"}, int'(alu_operation), expOp);
      checkOutput({name, "_operand"}, int'(alu_operand), expOperand);
      if (push) begin
         e.id     = expId;
         e.result = expRes;
         sbQ.push_back(e);
      end
      @(posedge clock);
      #1;
   endtask

   task automatic idleCycle();
      clearAll();
      applyStimulus("idle", 0, 0, 0, 1'b0, 0, 0);
   endtask

   task automatic doReset();
      clearAll();
      reset_L = 1'b0;
      @(negedge clock);
      checkOutput("rst_rspv", int'(rsp_valid), 0);
      checkOutput("rst_ready", int'(req_ready), 0);
      @(posedge clock);
      #1;
      reset_L = 1'b1;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired at %0t", $time);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      reset_L = 1'b0;
      clearAll();
      repeat (2) @(posedge clock);
      #1;

      // Reset state with no requests.
      @(negedge clock);
      checkOutput("reset_rspv", int'(rsp_valid), 0);
      checkOutput("reset_rspid", int'(rsp_id), 0);
      checkOutput("reset_ready", int'(req_ready), 0);
      checkOutput("reset_op", int'(alu_operation), 0);
      checkOutput("reset_operand", int'(alu_operand), 0);
      @(posedge clock);
      #1;
      reset_L = 1'b1;
      for (int c = 0; c < 3; c++) begin
         idleCycle();
         checkOutput("idle_acc", int'(alu_result), 0);
      end

      // Single request.
      setReq(0, 1'b1, 0, 5, 1'b1);
      applyStimulus("single", 1, 0, 5, 1'b1, 0, 5);
      idleCycle();
      doReset();

      // Fairness: all four valid, granted 0,1,2,3 back to back.
      for (int k = 0; k < 4; k++) setReq(k, 1'b1, 0, 1, 1'b1);
      for (int k = 0; k < 4; k++) begin
         applyStimulus("fair", 1 << k, 0, 1, 1'b1, k, k + 1);
         setReq(k, 1'b0, 0, 0, 1'b0);
      end
      idleCycle();
      doReset();

      // Lock: req2 stalls while req1 owns the ALU.
      setReq(1, 1'b1, 0, 3, 1'b0);
      setReq(2, 1'b1, 3, 1, 1'b1);
      applyStimulus("lock_first", 2, 0, 3, 1'b1, 1, 3);
      setReq(1, 1'b0, 0, 0, 1'b0);
      repeat (2) applyStimulus("lock_hold", 0, 0, 0, 1'b0, 0, 0);
      setReq(1, 1'b1, 1, 1, 1'b1);
      applyStimulus("lock_last", 2, 1, 1, 1'b1, 1, 2);
      setReq(1, 1'b0, 0, 0, 1'b0);
      applyStimulus("lock_next", 4, 3, 1, 1'b1, 2, 3);
      idleCycle();
      checkOutput("lock_acc", int'(alu_result), 3);
      doReset();

      // Timeout after exactly 4 idle locked cycles, no response for it.
      setReq(0, 1'b1, 0, 7, 1'b0);
      applyStimulus("to_lock", 1, 0, 7, 1'b1, 0, 7);
      setReq(0, 1'b0, 0, 0, 1'b0);
      setReq(3, 1'b1, 0, 2, 1'b1);
      repeat (4) applyStimulus("to_wait", 0, 0, 0, 1'b0, 0, 0);
      applyStimulus("to_grant", 8, 0, 2, 1'b1, 3, 9);
      idleCycle();
      doReset();

      // Owner transfers on the would-be expiring cycle: counter restarts.
      setReq(0, 1'b1, 0, 1, 1'b0);
      applyStimulus("sim_lock", 1, 0, 1, 1'b1, 0, 1);
      setReq(0, 1'b0, 0, 0, 1'b0);
      setReq(1, 1'b1, 0, 2, 1'b1);
      repeat (3) applyStimulus("sim_wait", 0, 0, 0, 1'b0, 0, 0);
      setReq(0, 1'b1, 1, 1, 1'b0);
      applyStimulus("sim_xfer", 1, 1, 1, 1'b1, 0, 0);
      setReq(0, 1'b0, 0, 0, 1'b0);
      repeat (4) applyStimulus("sim_rewait", 0, 0, 0, 1'b0, 0, 0);
      applyStimulus("sim_grant", 2, 0, 2, 1'b1, 1, 2);
      idleCycle();
      doReset();

      // Modulo-16 wrap both ways.
      setReq(0, 1'b1, 0, 15, 1'b1);
      applyStimulus("wrap15", 1, 0, 15, 1'b1, 0, 15);
      setReq(0, 1'b0, 0, 0, 1'b0);
      setReq(1, 1'b1, 0, 2, 1'b1);
      applyStimulus("wrap2", 2, 0, 2, 1'b1, 1, 1);
      setReq(1, 1'b0, 0, 0, 1'b0);
      setReq(2, 1'b1, 1, 3, 1'b1);
      applyStimulus("wrap_sub", 4, 1, 3, 1'b1, 2, 14);
      setReq(2, 1'b0, 0, 0, 1'b0);

      // Reset while locked drops the pending response and frees the ALU.
      setReq(3, 1'b1, 0, 1, 1'b0);
      applyStimulus("rst_lock", 8, 0, 1, 1'b0, 0, 0);
      clearAll();
      reset_L = 1'b0;
      @(negedge clock);
      checkOutput("rstlock_rspv", int'(rsp_valid), 0);
      checkOutput("rstlock_rspid", int'(rsp_id), 0);
      @(posedge clock);
      #1;
      reset_L = 1'b1;
      setReq(0, 1'b1, 0, 1, 1'b1);
      setReq(3, 1'b1, 0, 1, 1'b1);
      applyStimulus("rst_ptr", 1, 0, 1, 1'b1, 0, 1);
      setReq(0, 1'b0, 0, 0, 1'b0);
      applyStimulus("rst_next", 8, 0, 1, 1'b1, 3, 2);
      repeat (2) idleCycle();

      checkOutput("sb_empty", sbQ.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_rr_sched.md
# alu_rr_sched

Round-robin scheduler that shares the single 4-bit accumulator ALU (add/sub/or/xor against a free-running accumulator register) among NUM_REQ requesters. It arbitrates valid/ready requests and drives the ALU's operation/operand inputs. Each accepted request gets a one-cycle response carrying the post-operation accumulator value. Requesters can lock the ALU for multi-operation sequences, and an optional idle timeout reclaims abandoned locks. The ALU updates its accumulator every cycle, so the scheduler drives an explicit no-op (ADD 0) whenever nothing issues.

## Interface

- NUM_REQ, 4, number of requesters; legal range 2..8.
- LOCK_TIMEOUT, 8, idle cycles allowed while locked before forced release; 0 disables the timeout.
- IDW, $clog2(NUM_REQ), requester ID width (derived, not overridden).

Ports:

- clock  in  1  system clock, rising edge.
- reset_L  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_op  in  NUM_REQ×2  per-requester operation: 0 ADD, 1 SUB, 2 OR, 3 XOR.
- req_operand  in  NUM_REQ×4  per-requester operand.
- req_last  in  NUM_REQ  1 = release the ALU after this op; 0 = keep the lock.
- alu_operation  out  2  to the ALU operation input.
- alu_operand  out  4  to the ALU operand input.
- alu_result  in  4  ALU accumulator value.
- rsp_valid  out  1  response strobe.
- rsp_id  out  IDW  ID of the requester being answered.
- rsp_result  out  4  accumulator value after that requester's op.

## Operation

- **FSM states:**
  - IDLE: no owner.
  - LOCKED: owner holds the ALU.
- **IDLE arbitration:**
  - Winner is the first requester with req_valid=1, searching from rr_ptr upward with wrap.
  - req_ready is asserted combinationally for the winner only.
- **LOCKED:** only req_ready[owner] may assert, and it follows req_valid[owner]; all other requesters stall.
- **Transfer** = req_valid[i] & req_ready[i]. In the transfer cycle:
  - alu_operation and alu_operand come combinationally from requester i.
  - Otherwise alu_operation=0 and alu_operand=0 (no-op).
- **After a transfer:**
  - req_last=0 → LOCKED, owner=i.
  - req_last=1 → IDLE, rr_ptr=(i+1) mod NUM_REQ.
  - A lock may begin and end on the same requester's consecutive transfers.
- **Idle counter:**
  - Counts LOCKED cycles with no transfer; cleared on every transfer and on entry to LOCKED.
  - When it reaches LOCK_TIMEOUT (nonzero), next state is IDLE and rr_ptr=(owner+1) mod NUM_REQ.
  - No response is generated on a timeout.
- **Arithmetic:** modulo 16, performed by the ALU. Examples: 15+2=1, 0−1=15.
- **Requester rules:** must hold req_op, req_operand and req_last stable while valid and not ready.

## Timing

- **Reset values:**
  - State IDLE, rr_ptr 0, owner 0, idle counter 0.
  - rsp_valid 0, rsp_id 0.
  - req_ready 0 unless a requester is valid.
  - alu_operation 0, alu_operand 0.
- **Issue latency:** 0 cycles from valid to ready when the ALU is free.
- **Response:**
  - rsp_valid and rsp_id are registered and assert exactly 1 cycle after the transfer, for exactly 1 cycle.
  - rsp_result = alu_result in that cycle.
- **Throughput:** one transfer per cycle. Back-to-back transfers from different requesters produce back-to-back responses.
- **Reset mid-lock:** immediate return to IDLE; pending responses are dropped.
- **Simultaneous timeout and owner valid in the same cycle:** the transfer wins and the counter clears.

## Structure

- alu_pkg holds:
  - op encodings as an enum: ALU_ADD, ALU_SUB, ALU_OR, ALU_XOR.
  - ALU_NOP_OP=ALU_ADD and ALU_NOP_OPERAND=4'd0.
  - The FSM state enum: SCHED_IDLE, SCHED_LOCKED.
- Sub-module rr_arbiter (parameter N):
  - Inputs: req vector, rr_ptr.
  - Outputs: one-hot grant, grant index, any_grant.
- The top level holds the FSM, idle counter, response register and ALU mux.

## Test plan

- **Reset, no valids:** assert reset_L=0 then release → rsp_valid=0, req_ready=0, alu_operation=0 and alu_operand=0 every cycle, alu_result stays 0.
- **Single request:** req0 ADD 5, last=1 → ready same cycle; next cycle rsp_valid=1, rsp_id=0, rsp_result=5.
- **Fairness:** all 4 requesters valid with ADD 1, last=1 each, held until accepted → grants in order 0,1,2,3 on consecutive cycles; responses carry ids 0..3 with results 1,2,3,4.
- **Lock:**
  - Stimulus: req1 ADD 3, last=0, while req2 holds XOR 1.
  - req1 waits 2 cycles, then sends SUB 1, last=1.
  - Required response: req2 is not ready while req1 holds the lock.
  - Results in order: 3 (id1), 2 (id1), 3 (id2). The idle cycles leave the accumulator unchanged.
- **Timeout:** LOCK_TIMEOUT=4, req0 ADD 7, last=0, then idle while req3 is valid → released after exactly 4 idle cycles; req3 granted the next cycle; no response for req0's release.
- **Wrap and reset:**
  - ADD 15 then ADD 2 → responses 15 then 1.
  - SUB 3 from 1 → response 14.
  - reset_L pulsed while LOCKED → state IDLE, rr_ptr 0, rsp_valid 0.
